// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ADD/SUB/logic/SLT, radix-2 shift-add MUL over WIDTH cycles.
// One request in flight at a time; the result is held until the consumer takes it.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [2:0]       aluctrl_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             err_o
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, mcand, mplr;
    logic [WIDTH-1:0] alu_res, sum, diff, mul_step;
    logic             alu_ovf, alu_err;
    logic             accept, mul_last;

    assign ready_o  = (state == S_IDLE);
    assign valid_o  = (state == S_DONE);
    assign accept   = valid_i && ready_o;
    assign mul_last = (state == S_MUL) && (cnt == CNT_W'(WIDTH - 1));
    assign sum      = data0_i + data1_i;
    assign diff     = data0_i - data1_i;
    assign mul_step = acc + (mplr[0] ? mcand : '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (aluctrl_i == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:  if (mul_last) state_nxt = S_DONE;
            S_DONE: if (ready_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Overflow: operands of matching sign (ADD) or differing sign (SUB) yielding a flipped sign.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_err = 1'b0;
        case (aluctrl_i)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (data0_i[WIDTH-1] == data1_i[WIDTH-1]) && (sum[WIDTH-1] != data0_i[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (data0_i[WIDTH-1] != data1_i[WIDTH-1]) && (diff[WIDTH-1] != data0_i[WIDTH-1]);
            end
            OP_AND: alu_res = data0_i & data1_i;
            OP_OR:  alu_res = data0_i | data1_i;
            OP_XOR: alu_res = data0_i ^ data1_i;
            OP_SLT: alu_res = WIDTH'($signed(data0_i) < $signed(data1_i));
            OP_MUL: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplr   <= '0;
            data_o <= '0;
            zero_o <= 1'b0;
            ovf_o  <= 1'b0;
            err_o  <= 1'b0;
        end else if (accept) begin
            if (aluctrl_i == OP_MUL) begin
                mcand <= data0_i;
                mplr  <= data1_i;
                acc   <= '0;
                cnt   <= '0;
            end else begin
                data_o <= alu_res;
                zero_o <= (alu_res == '0);
                ovf_o  <= alu_ovf;
                err_o  <= alu_err;
            end
        end else if (state == S_MUL) begin
            // Multiplier consumed LSB first; bits shifted past WIDTH are dropped.
            acc   <= mul_step;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + CNT_W'(1);
            if (mul_last) begin
                data_o <= mul_step;
                zero_o <= (mul_step == '0);
                ovf_o  <= 1'b0;
                err_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: reset, vector table, handshake/reset corner sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_alu_multicycle;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_i = 1'b0;
    logic [W-1:0] data0_i = '0;
    logic [W-1:0] data1_i = '0;
    logic [2:0]   aluctrl_i = '0;
    logic         ready_o, valid_o, zero_o, ovf_o, err_o;
    logic [W-1:0] data_o;

    int passed = 0;
    int total  = 0;

    alu_multicycle #(.WIDTH(W), .CNT_W(6)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .data0_i(data0_i), .data1_i(data1_i), .aluctrl_i(aluctrl_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .zero_o(zero_o), .ovf_o(ovf_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, d;
        logic        z, o, e;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        z, o, e;
        int          lat;
        bit          stable, idle;
    } res_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    // Reference model straight from the arithmetic definitions, using 64-bit signed math.
    function automatic res_t ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        longint      sa, sb, full;
        logic [63:0] prod;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.o = 1'b0; r.e = 1'b0; r.d = '0; r.lat = 1; r.stable = 1'b1; r.idle = 1'b1;
        case (op)
            3'd0: begin full = sa + sb; r.d = full[31:0]; r.o = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
            3'd1: begin full = sa - sb; r.d = full[31:0]; r.o = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
            3'd2: begin prod = {32'd0, a} * {32'd0, b}; r.d = prod[31:0]; r.lat = W + 1; end
            3'd3: r.d = a & b;
            3'd4: r.d = a | b;
            3'd5: r.d = a ^ b;
            3'd6: r.d = (sa < sb) ? 32'd1 : 32'd0;
            default: r.e = 1'b1;
        endcase
        r.z = (r.d == 32'd0);
        return r;
    endfunction

    // Issue one request, wait (bounded) for the result, stall the consumer, then complete the handshake.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int stall, output res_t r);
        @(negedge clk_i);
        valid_i = 1'b1; aluctrl_i = op; data0_i = a; data1_i = b; ready_i = (stall == 0);
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0; data0_i = $urandom; data1_i = $urandom;
        r.lat = 1;
        while (!valid_o && r.lat < 100) begin
            @(negedge clk_i);
            r.lat++;
        end
        r.d = data_o; r.z = zero_o; r.o = ovf_o; r.e = err_o; r.stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk_i);
            if (!valid_o || ready_o || data_o !== r.d || zero_o !== r.z || ovf_o !== r.o || err_o !== r.e)
                r.stable = 1'b0;
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        r.idle = ready_o && !valid_o;
        ready_i = 1'b0;
    endtask

    task automatic chk_res(input string tag, input res_t r, input res_t x);
        chk({tag, " data"}, r.d, x.d);
        chk({tag, " flags zoe"}, {r.z, r.o, r.e}, {x.z, x.o, x.e});
        chk({tag, " latency"}, r.lat, x.lat);
        chk({tag, " held/idle"}, {r.stable, r.idle}, 2'b11);
    endtask

    initial begin
        res_t r, x;
        bit   leaked;
        int   n;

        vecs[0]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'd1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'd6, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'd6, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'd4, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd5, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'd2, 32'h00010001, 32'h00010001, 32'h00020001, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'd7, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{3'd0, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'd2, 32'h00000000, 32'h00001234, 32'h00000000, 1'b1, 1'b0, 1'b0};

        // Reset state, with a request already pending for the first post-reset edge.
        valid_i = 1'b1; aluctrl_i = 3'd0; data0_i = 32'd2; data1_i = 32'd3; ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("reset outputs", {ready_o, valid_o, data_o, zero_o, ovf_o, err_o}, {1'b1, 1'b0, 32'd0, 3'b000});
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        chk("first accept", {valid_o, data_o}, {1'b1, 32'd5});
        @(negedge clk_i);
        chk("first idle", {ready_o, valid_o}, 2'b10);
        ready_i = 1'b0;

        // Vector table.
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, r);
            x.d = vecs[i].d; x.z = vecs[i].z; x.o = vecs[i].o; x.e = vecs[i].e;
            x.lat = (vecs[i].op == 3'd2) ? 33 : 1;
            x.stable = 1'b1; x.idle = 1'b1;
            chk_res($sformatf("vec%0d", i), r, x);
        end

        // Invalid opcode with the consumer stalled for 5 cycles.
        run_op(3'd7, 32'hDEADBEEF, 32'h1, 5, r);
        chk_res("err stall", r, ref_alu(3'd7, 32'hDEADBEEF, 32'h1));

        // Stalled MUL holds its result.
        run_op(3'd2, 32'h00001234, 32'h00005678, 3, r);
        chk_res("mul stall", r, ref_alu(3'd2, 32'h00001234, 32'h00005678));

        // Reset pulse in the middle of a MUL.
        run_op(3'd0, 32'd2, 32'd3, 0, r);
        @(negedge clk_i);
        valid_i = 1'b1; aluctrl_i = 3'd2; data0_i = 32'd3; data1_i = 32'd7; ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (9) @(negedge clk_i);
        chk("mul busy at 10", {ready_o, valid_o}, 2'b00);
        rst_i = 1'b0;
        #1;
        chk("mid-mul reset", {valid_o, data_o, zero_o, ovf_o, err_o}, {1'b0, 32'd0, 3'b000});
        @(negedge clk_i);
        rst_i = 1'b1;
        leaked = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o || !ready_o) leaked = 1'b1;
        end
        chk("no result after abort", leaked, 1'b0);
        ready_i = 1'b0;
        run_op(3'd0, 32'd2, 32'd3, 0, r);
        chk_res("add after reset", r, ref_alu(3'd0, 32'd2, 32'd3));

        // New requests offered during a MUL are ignored.
        @(negedge clk_i);
        valid_i = 1'b1; aluctrl_i = 3'd2; data0_i = 32'h00ABCDEF; data1_i = 32'h00000F0F; ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        n = 1;
        while (n <= 20) begin
            valid_i = n[0]; aluctrl_i = 3'd0; data0_i = $urandom; data1_i = $urandom;
            @(negedge clk_i);
            n++;
        end
        valid_i = 1'b0;
        while (!valid_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        x = ref_alu(3'd2, 32'h00ABCDEF, 32'h00000F0F);
        chk("mul ignore data", data_o, x.d);
        chk("mul ignore latency", n, 33);
        @(negedge clk_i);
        chk("mul ignore idle", {ready_o, valid_o}, 2'b10);
        ready_i = 1'b0;

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = 32'h7FFFFFFF;
                2: a = 32'h80000000;
                default: ;
            endcase
            run_op(op, a, b, $urandom_range(0, 3), r);
            chk_res($sformatf("rnd%0d op%0d", i, op), r, ref_alu(op, a, b));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 Parameter: CNT_W, default 6, iteration counter width; SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 valid_i  input  1  request valid.
REQ-006 ready_o  output  1  block can accept a request.
REQ-007 data0_i  input  WIDTH  operand A.
REQ-008 data1_i  input  WIDTH  operand B.
REQ-009 aluctrl_i  input  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 XOR, 110 SLT, 111 invalid.
REQ-010 valid_o  output  1  result valid.
REQ-011 ready_i  input  1  consumer accepts result.
REQ-012 data_o  output  WIDTH  registered result.
REQ-013 zero_o  output  1  data_o == 0.
REQ-014 ovf_o  output  1  signed overflow (ADD/SUB only, else 0).
REQ-015 err_o  output  1  invalid opcode flag.

Function
REQ-016 States SHALL be IDLE, MUL, DONE; ready_o SHALL be 1 only in IDLE.
REQ-017 Request accepted on a rising edge where valid_i && ready_o; data0_i, data1_i, aluctrl_i sampled only then.
REQ-018 Non-MUL opcode accepted: IDLE -> DONE, result written to data_o on the same edge; valid_o high in the next cycle (latency 1).
REQ-019 MUL accepted: IDLE -> MUL, counter cleared, accumulator cleared, operands latched.
REQ-020 MUL: radix-2 shift-add, one multiplier bit per cycle LSB first, exactly WIDTH cycles in MUL; then MUL -> DONE; valid_o asserted WIDTH+1 cycles after accept edge.
REQ-021 MUL result: low WIDTH bits of unsigned product; upper bits discarded, ovf_o = 0.
REQ-022 ADD/SUB: modulo 2**WIDTH; ovf_o = two's-complement signed overflow of the operation.
REQ-023 SLT: data_o = 1 if data0 < data1 signed, else 0.
REQ-024 Opcode 111: data_o = 0, err_o = 1, zero_o = 1, latency 1 like non-MUL ops.
REQ-025 zero_o, ovf_o, err_o SHALL be registered with data_o and valid only while valid_o = 1.
REQ-026 DONE: valid_o = 1; data_o and flags held stable until valid_o && ready_i on a rising edge, then DONE -> IDLE.
REQ-027 ready_i high in the same cycle valid_o first rises SHALL complete the output handshake on that edge (no extra wait).
REQ-028 valid_i and operand changes while not IDLE SHALL be ignored; no request queuing.
REQ-029 Minimum issue interval: non-MUL 2 cycles, MUL WIDTH+2 cycles with ready_i held 1.

Reset
REQ-030 rst_i = 0 SHALL immediately force state IDLE, counter 0, accumulator 0, data_o 0, valid_o 0, zero_o 0, ovf_o 0, err_o 0, ready_o 1 after release.
REQ-031 Reset asserted mid-MUL or in DONE SHALL abort the operation; no result emitted after release.
REQ-032 First request SHALL be accepted on the first rising edge with rst_i = 1 and valid_i = 1.

Verification
REQ-033 WIDTH=32, ADD 0x7FFFFFFF + 1, ready_i=1 -> valid_o next cycle, data_o 0x80000000, ovf_o 1, zero_o 0.
REQ-034 SUB 5 - 5 -> data_o 0, zero_o 1, ovf_o 0; SLT 0xFFFFFFFF vs 1 -> data_o 1.
REQ-035 MUL 0x00010001 * 0x00010001 -> ready_o low 33 cycles, valid_o at cycle 33 after accept, data_o 0x00020001.
REQ-036 Opcode 111 with ready_i=0 for 5 cycles -> valid_o, data_o 0, err_o 1 held stable; ready_o 0 throughout; IDLE one edge after ready_i=1.
REQ-037 Reset pulse at MUL cycle 10 -> all outputs 0 immediately; after release, new ADD 2+3 -> data_o 5 in 1 cycle.
REQ-038 valid_i toggled with new operands during MUL -> ignored; result matches the first accepted request.
